// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO push arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int unsigned def_num_req    = 4;
   localparam int unsigned def_fifo_width = 32;
   localparam int unsigned def_max_burst  = 4;

   // Index/counter width that never collapses to zero bits.
   function automatic int unsigned width_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: first set request after last_owner, wrapping modulo num_req.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned num_req = def_num_req,
   parameter int unsigned idx_w   = width_min1(num_req)
) (
   input  logic [num_req-1:0] req,
   input  logic [idx_w-1:0]   last_owner,
   output logic               valid,
   output logic [idx_w-1:0]   pick
);

   localparam logic [idx_w-1:0] top_idx = idx_w'(num_req - 1);

   logic [idx_w-1:0] cand;

   always_comb begin
      valid = 1'b0;
      pick  = '0;
      cand  = last_owner;
      // Walk num_req candidates starting just past last_owner; last_owner itself is checked last.
      for (int unsigned off = 0; off < num_req; off++) begin
         cand = (cand == top_idx) ? '0 : cand + idx_w'(1);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            pick  = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO write port between num_req producers, granting round-robin bursts
// of up to max_burst words and stalling on fifo_full.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned num_req    = def_num_req,
   parameter int unsigned fifo_width = def_fifo_width,
   parameter int unsigned max_burst  = def_max_burst
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [num_req-1:0]            req,
   input  logic [num_req-1:0]            req_last,
   input  logic [num_req*fifo_width-1:0] req_data,
   output logic [num_req-1:0]            req_ack,
   output logic [num_req-1:0]            grant,
   output logic                          busy,
   input  logic                          fifo_full,
   output logic                          push,
   output logic [fifo_width-1:0]         fifo_data
);

   localparam int unsigned idx_w = width_min1(num_req);
   localparam int unsigned cnt_w = width_min1(max_burst);
   localparam logic [cnt_w-1:0] last_count = cnt_w'(max_burst - 1);
   localparam logic [idx_w-1:0] top_idx    = idx_w'(num_req - 1);

   arb_state_t       state;
   logic [idx_w-1:0] owner;
   logic [idx_w-1:0] last_owner;
   logic [cnt_w-1:0] count;

   logic             pick_valid;
   logic [idx_w-1:0] pick;
   logic [num_req-1:0] pick_onehot;

   logic                  owner_req;
   logic                  owner_last;
   logic [fifo_width-1:0] owner_data;

   rr_pick #(
      .num_req (num_req),
      .idx_w   (idx_w)
   ) u_rr_pick (
      .req        (req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .pick       (pick)
   );

   always_comb begin
      pick_onehot       = '0;
      pick_onehot[pick] = 1'b1;
   end

   always_comb begin
      owner_req  = 1'b0;
      owner_last = 1'b0;
      owner_data = '0;
      for (int unsigned i = 0; i < num_req; i++) begin
         if (owner == idx_w'(i)) begin
            owner_req  = req[i];
            owner_last = req_last[i];
            owner_data = req_data[i*fifo_width +: fifo_width];
         end
      end
   end

   // Gating with reset keeps a mid-burst reset from pushing in the cycle it is applied.
   always_comb begin
      push      = 1'b0;
      req_ack   = '0;
      fifo_data = '0;
      if (state == BURST) begin
         fifo_data = owner_data;
         push      = owner_req && !fifo_full && !reset;
         if (push) begin
            req_ack = grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         busy       <= 1'b0;
         count      <= '0;
         owner      <= '0;
         last_owner <= top_idx;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state <= BURST;
                  grant <= pick_onehot;
                  owner <= pick;
                  busy  <= 1'b1;
                  count <= '0;
               end
            end
            BURST: begin
               if (push) begin
                  if (owner_last || count == last_count) begin
                     state      <= IDLE;
                     grant      <= '0;
                     busy       <= 1'b0;
                     count      <= '0;
                     last_owner <= owner;
                  end else begin
                     count <= count + cnt_w'(1);
                  end
               end else if (!owner_req) begin
                  state      <= IDLE;
                  grant      <= '0;
                  busy       <= 1'b0;
                  count      <= '0;
                  last_owner <= owner;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
